// File: rtl/decode_sequencer.sv
// Instruction decode sequencer: accepts one opcode per cycle in IDLE and
// produces registered control pulses. It stalls in a wait state for
// multi-cycle MULT, for the input handshake of STIN and for the output
// handshake of LOUT. A taken branch discards the next FLUSH_SLOTS accepted
// instructions.
module decode_sequencer #(
    parameter int OPW         = 6,
    parameter int FUNCW       = 3,
    parameter int MULT_CYCLES = 4,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [OPW-1:0]   opcode,
    input  logic             ZF,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             instr_ready,
    output logic [FUNCW-1:0] alu_func,
    output logic             reg_write,
    output logic             immediate,
    output logic             read_in,
    output logic             pc_rel_branch,
    output logic             write_out,
    output logic             mult_busy,
    output logic             illegal_op
);

    // Opcode map; the low FUNCW bits double as the ALU function select,
    // so ADDI/SUBI share their ALU function with ADD/SUB.
    localparam logic [OPW-1:0] OP_NOP  = OPW'(6'h00);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(6'h01);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6'h02);
    localparam logic [OPW-1:0] OP_MULT = OPW'(6'h03);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6'h09);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(6'h0A);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'h10);
    localparam logic [OPW-1:0] OP_BNQ  = OPW'(6'h11);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(6'h12);
    localparam logic [OPW-1:0] OP_STIN = OPW'(6'h18);
    localparam logic [OPW-1:0] OP_LOUT = OPW'(6'h19);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] MULT_WAIT = 2'd1;
    localparam logic [1:0] IN_WAIT   = 2'd2;
    localparam logic [1:0] OUT_WAIT  = 2'd3;

    logic [1:0] state;
    logic [1:0] flush_cnt;
    logic [3:0] mult_cnt;
    logic       accept;
    logic       flushing;
    logic       br_taken;
    logic       is_branch;

    assign instr_ready = (state == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign flushing    = (flush_cnt != 2'd0);
    assign write_out   = (state == OUT_WAIT);
    assign mult_busy   = (state == MULT_WAIT);

    // Branch resolution uses the ZF sampled with the opcode.
    always_comb begin
        br_taken  = 1'b0;
        is_branch = 1'b0;
        case (opcode)
            OP_BEQ:  begin is_branch = 1'b1; br_taken = ZF;   end
            OP_BNQ:  begin is_branch = 1'b1; br_taken = !ZF;  end
            OP_JMP:  begin is_branch = 1'b1; br_taken = 1'b1; end
            default: ;
        endcase
    end

    // Sequencer state, counters and one-cycle control pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            flush_cnt     <= 2'd0;
            mult_cnt      <= 4'd0;
            alu_func      <= '0;
            reg_write     <= 1'b0;
            immediate     <= 1'b0;
            read_in       <= 1'b0;
            pc_rel_branch <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            reg_write     <= 1'b0;
            immediate     <= 1'b0;
            read_in       <= 1'b0;
            pc_rel_branch <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_func <= opcode[FUNCW-1:0];
                        if (flushing) begin
                            // Discarded slot: no effect besides consuming it.
                            flush_cnt <= flush_cnt - 2'd1;
                        end else if (is_branch) begin
                            pc_rel_branch <= br_taken;
                            if (br_taken)
                                flush_cnt <= 2'(FLUSH_SLOTS);
                        end else begin
                            case (opcode)
                                OP_NOP: ;
                                OP_ADD, OP_SUB: reg_write <= 1'b1;
                                OP_ADDI, OP_SUBI: begin
                                    reg_write <= 1'b1;
                                    immediate <= 1'b1;
                                end
                                OP_MULT: begin
                                    if (MULT_CYCLES <= 1) begin
                                        reg_write <= 1'b1;
                                    end else begin
                                        // Counts the remaining busy cycles after the first.
                                        state    <= MULT_WAIT;
                                        mult_cnt <= 4'(MULT_CYCLES - 2);
                                    end
                                end
                                OP_STIN: state <= IN_WAIT;
                                OP_LOUT: state <= OUT_WAIT;
                                default: illegal_op <= 1'b1;
                            endcase
                        end
                    end
                end
                MULT_WAIT: begin
                    if (mult_cnt == 4'd0) begin
                        state     <= IDLE;
                        reg_write <= 1'b1;
                    end else begin
                        mult_cnt <= mult_cnt - 4'd1;
                    end
                end
                IN_WAIT: begin
                    if (in_valid) begin
                        state     <= IDLE;
                        read_in   <= 1'b1;
                        reg_write <= 1'b1;
                    end
                end
                OUT_WAIT: begin
                    // write_out is held until the cycle the sink takes it.
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Bench for decode_sequencer: a vector table of single-cycle instructions
// checked through a scoreboard queue, plus hand sequences for MULT, STIN,
// LOUT, illegal opcodes and reset.
module tb_decode_sequencer;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_MULT = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_SUBI = 6'h0A;
    localparam logic [5:0] OP_BEQ  = 6'h10;
    localparam logic [5:0] OP_BNQ  = 6'h11;
    localparam logic [5:0] OP_JMP  = 6'h12;
    localparam logic [5:0] OP_STIN = 6'h18;
    localparam logic [5:0] OP_LOUT = 6'h19;
    localparam logic [5:0] OP_BAD  = 6'h3F;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic [5:0] opcode = '0;
    logic       ZF = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       instr_ready;
    logic [2:0] alu_func;
    logic       reg_write, immediate, read_in, pc_rel_branch;
    logic       write_out, mult_busy, illegal_op;

    decode_sequencer #(.OPW(6), .FUNCW(3), .MULT_CYCLES(4), .FLUSH_SLOTS(1)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .ZF(ZF), .in_valid(in_valid), .out_ready(out_ready),
        .instr_ready(instr_ready), .alu_func(alu_func), .reg_write(reg_write),
        .immediate(immediate), .read_in(read_in), .pc_rel_branch(pc_rel_branch),
        .write_out(write_out), .mult_busy(mult_busy), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       zf;
        logic       rw, imm, br;
        logic [2:0] func;
    } vec_t;

    typedef struct {
        int         due;
        logic       rw, imm, br;
        logic [2:0] func;
    } exp_t;

    vec_t tbl [16];
    exp_t sb [$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (write_out && out_ready) xfers <= xfers + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the oldest expectation once its cycle arrives.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("tbl reg_write", {31'd0, reg_write}, {31'd0, e.rw});
            chk("tbl immediate", {31'd0, immediate}, {31'd0, e.imm});
            chk("tbl pc_rel_branch", {31'd0, pc_rel_branch}, {31'd0, e.br});
            chk("tbl alu_func", {29'd0, alu_func}, {29'd0, e.func});
            chk("tbl instr_ready", {31'd0, instr_ready}, 32'd1);
        end
    end

    initial begin
        // ADDI/SUB/ADD back to back, branches with and without flush.
        tbl[0]  = '{OP_ADDI, 1'b0, 1'b1, 1'b1, 1'b0, 3'd1};
        tbl[1]  = '{OP_SUB,  1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[2]  = '{OP_ADD,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[3]  = '{OP_NOP,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{OP_BEQ,  1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{OP_ADD,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[6]  = '{OP_BNQ,  1'b1, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[7]  = '{OP_BEQ,  1'b1, 1'b0, 1'b0, 1'b1, 3'd0};
        tbl[8]  = '{OP_ADD,  1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
        tbl[9]  = '{OP_SUB,  1'b0, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[10] = '{OP_JMP,  1'b0, 1'b0, 1'b0, 1'b1, 3'd2};
        tbl[11] = '{OP_BEQ,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[12] = '{OP_ADD,  1'b0, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[13] = '{OP_BNQ,  1'b0, 1'b0, 1'b0, 1'b1, 3'd1};
        tbl[14] = '{OP_SUBI, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
        tbl[15] = '{OP_SUBI, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2};

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst instr_ready", {31'd0, instr_ready}, 32'd0);
        chk("rst alu_func", {29'd0, alu_func}, 32'd0);
        chk("rst outputs", {27'd0, reg_write, immediate, read_in, pc_rel_branch, write_out},
            32'd0);
        chk("rst busy/illegal", {30'd0, mult_busy, illegal_op}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ready after reset", {31'd0, instr_ready}, 32'd1);
        tick();

        // Vector table through the scoreboard
        foreach (tbl[i]) begin
            opcode = tbl[i].op;
            ZF = tbl[i].zf;
            instr_valid = 1'b1;
            sb.push_back('{cyc + 1, tbl[i].rw, tbl[i].imm, tbl[i].br, tbl[i].func});
            tick();
        end
        instr_valid = 1'b0;
        ZF = 1'b0;
        tick();
        tick();
        chk("scoreboard drained", sb.size(), 32'd0);

        // MULT with a second instruction held valid behind it
        opcode = OP_MULT;
        instr_valid = 1'b1;
        tick();
        opcode = OP_ADD;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("mult busy", {31'd0, mult_busy}, 32'd1);
            chk("mult ready low", {31'd0, instr_ready}, 32'd0);
            chk("mult no rw", {31'd0, reg_write}, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("mult done rw", {31'd0, reg_write}, 32'd1);
        chk("mult done busy", {31'd0, mult_busy}, 32'd0);
        chk("mult done ready", {31'd0, instr_ready}, 32'd1);
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("held add rw", {31'd0, reg_write}, 32'd1);
        chk("held add func", {29'd0, alu_func}, 32'd1);
        tick();

        // in_valid ignored in IDLE, then STIN with a late in_valid
        in_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("idle in_valid ignored", {30'd0, read_in, reg_write}, 32'd0);
        in_valid = 1'b0;
        opcode = OP_STIN;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) in_valid = 1'b1;
            @(negedge clk);
            chk("stin wait", {30'd0, read_in, instr_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stin read_in", {31'd0, read_in}, 32'd1);
        chk("stin reg_write", {31'd0, reg_write}, 32'd1);
        chk("stin ready", {31'd0, instr_ready}, 32'd1);
        tick();
        @(negedge clk);
        chk("stin pulse ends", {30'd0, read_in, reg_write}, 32'd0);

        // LOUT with out_ready low for two cycles
        begin
            int x0;
            x0 = xfers;
            opcode = OP_LOUT;
            instr_valid = 1'b1;
            tick();
            instr_valid = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (k == 3) out_ready = 1'b1;
                @(negedge clk);
                chk("lout write_out held", {31'd0, write_out}, 32'd1);
                chk("lout ready low", {31'd0, instr_ready}, 32'd0);
                tick();
            end
            out_ready = 1'b0;
            @(negedge clk);
            chk("lout released", {30'd0, write_out, instr_ready}, 32'd1);
            chk("lout one transfer", xfers - x0, 32'd1);
        end

        // LOUT with out_ready already high
        out_ready = 1'b1;
        opcode = OP_LOUT;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("lout fast write_out", {31'd0, write_out}, 32'd1);
        tick();
        @(negedge clk);
        chk("lout fast done", {30'd0, write_out, instr_ready}, 32'd1);
        out_ready = 1'b0;
        tick();

        // Illegal opcode is sticky across later instructions
        opcode = OP_BAD;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("illegal set", {31'd0, illegal_op}, 32'd1);
        chk("illegal no pulses", {29'd0, reg_write, immediate, pc_rel_branch}, 32'd0);
        chk("illegal ready", {31'd0, instr_ready}, 32'd1);
        opcode = OP_ADD;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("illegal sticky", {31'd0, illegal_op}, 32'd1);
        chk("add after illegal", {31'd0, reg_write}, 32'd1);

        // Reset during MULT_WAIT aborts the multiply
        opcode = OP_MULT;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset ready", {31'd0, instr_ready}, 32'd1);
        chk("post-reset illegal", {31'd0, illegal_op}, 32'd0);
        chk("post-reset busy", {31'd0, mult_busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("aborted mult no rw", {31'd0, reg_write}, 32'd0);
            tick();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 6: opcode width; opcode values are the existing opcode definitions, zero-extended to OPW.
REQ-002 SHALL have parameter FUNCW, default 3: ALU function width, taken from opcode[FUNCW-1:0].
REQ-003 SHALL have parameter MULT_CYCLES, default 4, legal range 1..15: MULT latency in cycles.
REQ-004 SHALL have parameter FLUSH_SLOTS, default 1, legal range 0..3: number of accepted instructions discarded after a taken branch.
REQ-005 SHALL have ports clk (in, 1, clock) and reset (in, 1, synchronous active-high reset), in that order.
REQ-006 SHALL have inputs instr_valid (1, opcode present), opcode (OPW, instruction opcode), ZF (1, ALU zero flag), in_valid (1, input switch data ready) and out_ready (1, output sink ready).
REQ-007 SHALL have outputs instr_ready (1, can accept), alu_func (FUNCW, registered function), reg_write, immediate, read_in, pc_rel_branch (1 each, single-cycle pulses), write_out (1, held output request), mult_busy (1) and illegal_op (1, sticky).

Function
REQ-008 SHALL accept an instruction in cycle T when instr_valid and instr_ready are both 1; opcode and ZF are sampled in cycle T.
REQ-009 SHALL use FSM states IDLE, MULT_WAIT, IN_WAIT and OUT_WAIT; instr_ready = 1 only in IDLE with reset low.
REQ-010 SHALL load alu_func from the accepted opcode[FUNCW-1:0] at T+1 and hold it until the next acceptance.
REQ-011 SHALL handle ADD/SUB as reg_write pulse at T+1, and ADDI/SUBI as reg_write and immediate pulses at T+1; the FSM stays in IDLE (one instruction per cycle).
REQ-012 SHALL handle NOP with no pulses and the FSM in IDLE.
REQ-013 SHALL handle BEQ as pc_rel_branch = sampled ZF at T+1, BNQ as pc_rel_branch = ~ZF at T+1, and JMP as pc_rel_branch = 1 at T+1.
REQ-014 SHALL, on a taken branch, load the flush counter with FLUSH_SLOTS; each subsequent acceptance while the counter is nonzero produces no pulses, causes no state change and decrements the counter.
REQ-015 SHALL discard a branch accepted during a flush without reloading the counter.
REQ-016 SHALL handle MULT with MULT_CYCLES = 1 exactly like ADD.
REQ-017 SHALL handle MULT with MULT_CYCLES > 1 as: enter MULT_WAIT, mult_busy = 1 for T+1..T+MULT_CYCLES-1, reg_write pulse at T+MULT_CYCLES, return to IDLE with instr_ready = 1 in that same cycle.
REQ-018 SHALL handle STIN as: enter IN_WAIT; in the cycle after the first cycle in_valid = 1 is sampled in IN_WAIT, pulse read_in and reg_write and return to IDLE.
REQ-019 SHALL ignore in_valid outside IN_WAIT.
REQ-020 SHALL handle LOUT as: enter OUT_WAIT, write_out = 1 from T+1 and held through the first cycle with out_ready = 1 inclusive (the transfer); return to IDLE the next cycle.
REQ-021 SHALL treat a LOUT accepted when out_ready is already 1 as a one-cycle write_out at T+1.
REQ-022 SHALL, for an undefined opcode, set illegal_op at T+1, hold it until reset, produce no other pulses and leave the FSM in IDLE.
REQ-023 SHALL have no pulse lasting more than one cycle unless the next instruction produces it again.

Reset
REQ-024 SHALL, while reset = 1 at a clock edge, force state IDLE, flush counter 0, MULT counter 0, alu_func 0, all pulses 0, write_out 0, mult_busy 0, illegal_op 0 and instr_ready 0.
REQ-025 SHALL assert instr_ready in the first cycle after reset deasserts.
REQ-026 SHALL abort any in-progress MULT/STIN/LOUT on reset, producing no completion pulse.

Verification
REQ-027 SHALL be verified by: back-to-back ADDI, SUB, ADD in cycles 1-3 -> reg_write 1 in cycles 2-4, immediate 1 only in cycle 2, alu_func tracks each opcode, instr_ready constantly 1.
REQ-028 SHALL be verified by: MULT_CYCLES=4, MULT at T=5 -> mult_busy in cycles 6-8, reg_write in cycle 9, instr_ready 0 in cycles 6-8; a second instruction held valid is accepted in cycle 9.
REQ-029 SHALL be verified by: FLUSH_SLOTS=1, BEQ with ZF=1 then ADD then SUB -> pc_rel_branch pulse, ADD produces no pulse, SUB reg_write; BEQ with ZF=0 -> no pulse, no flush.
REQ-030 SHALL be verified by: STIN with in_valid raised 3 cycles later -> read_in/reg_write one cycle after; LOUT with out_ready low 2 cycles -> write_out held 3 cycles, exactly one transfer.
REQ-031 SHALL be verified by: opcode 6'h3F -> illegal_op stays 1 across later valid instructions until reset; reset during MULT_WAIT -> no reg_write, instr_ready 1 the cycle after reset.
